pn_agc_shift: RTL
=================

PN_AGC_SHIFT -- requirements
Module: pn_agc_shift

Interface
REQ-001 Parameter IN_WDTH, default 40, signed input sample width.
REQ-002 Parameter OUT_WDTH, default 24, signed output sample width; IN_WDTH-OUT_WDTH >= 1.
REQ-003 Parameter GMAX, default 15, highest gain index; GMAX <= IN_WDTH-OUT_WDTH+4.
REQ-004 Parameter WIN_LEN, default 1024, valid samples per AGC measurement window; power of two, >= 4.
REQ-005 Clk  in  1  single clock; all logic rising-edge.
REQ-006 RstN  in  1  asynchronous, active-low reset.
REQ-007 Din  in  IN_WDTH  signed sample.
REQ-008 DinVld  in  1  Din qualifier; no backpressure.
REQ-009 AutoEn  in  1  1 = AGC loop, 0 = manual gain.
REQ-010 GCtrl  in  4  manual gain index; also the AGC start gain.
REQ-011 Dout  out  OUT_WDTH  scaled, rounded, saturated sample (registered).
REQ-012 DoutVld  out  1  Dout qualifier.
REQ-013 GainOut  out  4  gain index applied to the sample currently on Dout.
REQ-014 SatFlag  out  1  high with DoutVld when that sample saturated.

Function
REQ-015 Gain index G SHALL give Dout = sat(round(Din * 2^G / 2^(IN_WDTH-OUT_WDTH))). s = IN_WDTH-OUT_WDTH-G: arithmetic right shift when s > 0, left shift by -s when s < 0.
REQ-016 Rounding SHALL be round-half-up: add 2^(s-1) before the right shift. No rounding when s <= 0. Internal width IN_WDTH+5 bits, so nothing is lost before saturation.
REQ-017 Saturation SHALL clamp to [-2^(OUT_WDTH-1), 2^(OUT_WDTH-1)-1] and assert SatFlag for that sample.
REQ-018 Pipeline: stage 1 registers Din and G; stage 2 registers round/saturate. DoutVld SHALL assert exactly 2 cycles after DinVld; Dout, SatFlag and GainOut update only with DoutVld.
REQ-019 Manual mode: G = min(GCtrl, GMAX), sampled on each valid input.
REQ-020 AGC FSM states: MANUAL, MEASURE, ADJUST.
  - Entry to MEASURE: AutoEn rises. G loads from min(GCtrl, GMAX) and window counters clear.
  - Exit to MANUAL: AutoEn falls, from any state, on the next cycle.
REQ-021 MEASURE SHALL track, over WIN_LEN valid stage-2 outputs:
  - sat_seen = any SatFlag;
  - peak = max |pre-saturation result|, saturating at 2^(OUT_WDTH-1).
  When the WIN_LEN-th sample completes, the FSM goes to ADJUST.
REQ-022 ADJUST, one cycle:
  - if sat_seen and G > 0: G-1;
  - else if peak < 2^(OUT_WDTH-3) and G < GMAX: G+1;
  - else G unchanged.
  The FSM then returns to MEASURE with the counter and peak cleared.
REQ-023 New G SHALL apply from the first sample accepted after the ADJUST cycle. Samples arriving during ADJUST SHALL use the old G and SHALL NOT count toward the new window.
REQ-024 Samples still in the pipeline when a window closes SHALL NOT count toward the next window.
REQ-025 GCtrl changes while AutoEn=1 SHALL be ignored.

Reset
REQ-026 RstN low SHALL asynchronously clear:
  - Dout, DoutVld, SatFlag, GainOut, pipeline valids, window counter, peak, sat_seen: all 0;
  - G: 0;
  - FSM: MANUAL.
REQ-027 After RstN deasserts, the first output SHALL occur 2 cycles after the first DinVld. If AutoEn=1 at deassertion, the FSM SHALL enter MEASURE with G = min(GCtrl, GMAX). Reset mid-window discards that window.

Structure
REQ-028 Shared package pn_pkg SHALL hold:
  - the FSM state enum;
  - the gain-index width constant (4);
  - the parameter-legality checks.
REQ-029 Round and saturate SHALL be one combinational sub-module, pn_round_sat, parametrised on input/output width. FSM, counters and peak detector SHALL stay in the top level.

Verification (IN_WDTH=40, OUT_WDTH=24, GMAX=15, WIN_LEN=16)
REQ-030 Manual rounding: AutoEn=0, GCtrl=0.
  - Din=98304 -> Dout=2, 2 cycles later.
  - Din=-98304 -> Dout=-1.
  - SatFlag=0 for both.
REQ-031 Saturation: GCtrl=15, Din=2^30 -> Dout=0x7FFFFF, SatFlag=1. Din=-2^30 -> Dout=0x800000, SatFlag=1.
REQ-032 AGC up: AutoEn=1, GCtrl=0, continuous Din=2^20 -> GainOut steps +1 per window, reaches 15 after 15 windows and holds. Final Dout=2^19.
REQ-033 AGC down: AutoEn=1, GCtrl=4, continuous Din=2^38 -> GainOut steps 4,3,2,1,0 over four windows, then holds at 0 with Dout=2^22 and SatFlag=0.
REQ-034 Boundaries: DinVld held high across ADJUST, pinned G=0 with saturation, pinned G=15 with small peak -> G never wraps; no sample dropped or double-counted.
REQ-035 Control events mid-window:
  - RstN pulse -> all outputs 0 within the same cycle.
  - AutoEn toggle -> MANUAL next cycle, window discarded.

Source files
------------

// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - shared types, constants and parameter checks for pn_agc_shift
// Holds the AGC FSM state enum, the gain-index width, the gain clip helper
// and the parameter-legality function used at elaboration.
package pn_pkg;

    localparam int GW = 4;

    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_ADJUST  = 2'd2
    } pn_state_t;

    function automatic bit pn_params_ok(input int in_w, input int out_w,
                                        input int gmax, input int win_len);
        return (in_w - out_w >= 1) &&
               (gmax >= 0) && (gmax < (1 << GW)) &&
               (gmax <= in_w - out_w + 4) &&
               (win_len >= 4) && ((win_len & (win_len - 1)) == 0);
    endfunction

    function automatic logic [GW-1:0] pn_gclip(input logic [GW-1:0] g, input int gmax);
        return (int'(g) > gmax) ? GW'(gmax) : g;
    endfunction

endpackage

// File: rtl/pn_round_sat.sv
// rtl/pn_round_sat.sv - combinational gain shift, round-half-up and saturate
// Ports:
//   din  - signed input sample (IN_W bits)
//   g    - gain index; net shift s = IN_W-OUT_W-g (right when s>0, left when s<0)
//   dout - saturated signed result (OUT_W bits)
//   sat  - result was clamped
//   mag  - |pre-saturation result|, capped at 2^(OUT_W-1)
module pn_round_sat
    import pn_pkg::*;
#(
    parameter int IN_W  = 40,
    parameter int OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic        [GW-1:0]    g,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat,
    output logic        [OUT_W-1:0] mag
);

    // Five guard bits cover the largest left shift (4) plus the sign.
    localparam int IW = IN_W + 5;
    localparam int D  = IN_W - OUT_W;

    localparam logic signed [IW-1:0] ONE  = IW'(1);
    localparam logic signed [IW-1:0] MAXV = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [IW-1:0] CAP  = {{(IW-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IW-1:0] x;
    logic signed [IW-1:0] pre;
    logic signed [IW-1:0] absv;

    always_comb begin
        x = {{5{din[IN_W-1]}}, din};
        if (int'(g) < D) begin
            pre = (x + (ONE <<< (D - int'(g) - 1))) >>> (D - int'(g));
        end else begin
            pre = x <<< (int'(g) - D);
        end

        sat  = 1'b0;
        dout = pre[OUT_W-1:0];
        if (pre > MAXV) begin
            dout = MAXV[OUT_W-1:0];
            sat  = 1'b1;
        end else if (pre < MINV) begin
            dout = MINV[OUT_W-1:0];
            sat  = 1'b1;
        end

        absv = pre[IW-1] ? -pre : pre;
        mag  = (absv > CAP) ? CAP[OUT_W-1:0] : absv[OUT_W-1:0];
    end

endmodule

// File: rtl/pn_agc_shift.sv
// rtl/pn_agc_shift.sv - two-stage gain shifter with windowed AGC loop
// Ports:
//   Clk, RstN        - clock, asynchronous active-low reset
//   Din, DinVld      - signed input sample and qualifier (no backpressure)
//   AutoEn           - 1 = AGC loop, 0 = manual gain
//   GCtrl            - manual gain index, also the AGC start gain
//   Dout, DoutVld    - scaled/rounded/saturated sample, 2 cycles after DinVld
//   GainOut, SatFlag - gain used for, and saturation of, the sample on Dout
module pn_agc_shift
    import pn_pkg::*;
#(
    parameter int IN_WDTH  = 40,
    parameter int OUT_WDTH = 24,
    parameter int GMAX     = 15,
    parameter int WIN_LEN  = 1024
) (
    input  logic                       Clk,
    input  logic                       RstN,
    input  logic signed [IN_WDTH-1:0]  Din,
    input  logic                       DinVld,
    input  logic                       AutoEn,
    input  logic        [GW-1:0]       GCtrl,
    output logic signed [OUT_WDTH-1:0] Dout,
    output logic                       DoutVld,
    output logic        [GW-1:0]       GainOut,
    output logic                       SatFlag
);

    if (!pn_params_ok(IN_WDTH, OUT_WDTH, GMAX, WIN_LEN)) begin : g_param_check
        $error("pn_agc_shift: illegal parameter combination");
    end

    localparam int CW = $clog2(WIN_LEN);
    localparam logic [CW-1:0]       LAST     = CW'(WIN_LEN - 1);
    localparam logic [OUT_WDTH-1:0] LOW_PEAK = {3'b001, {(OUT_WDTH-3){1'b0}}};
    localparam logic [GW-1:0]       GMAX_G   = GW'(GMAX);

    pn_state_t                  state;
    logic [GW-1:0]              g_reg;
    logic [GW-1:0]              g_man;
    logic [GW-1:0]              g_use;
    logic                       epoch;

    logic                       v1;
    logic signed [IN_WDTH-1:0]  d1;
    logic [GW-1:0]              g1;
    logic                       c1;
    logic                       e1;

    logic signed [OUT_WDTH-1:0] rs_dout;
    logic                       rs_sat;
    logic [OUT_WDTH-1:0]        rs_mag;

    logic [CW-1:0]              win_cnt;
    logic [OUT_WDTH-1:0]        peak;
    logic                       sat_seen;
    logic                       count_now;

    assign g_man = pn_gclip(GCtrl, GMAX);
    assign g_use = (state == ST_MANUAL) ? g_man : g_reg;

    // A sample counts only if it was accepted in MEASURE of the window that is
    // still open: epoch flips whenever a window closes or the loop (re)starts,
    // so samples in flight across a window boundary are dropped from stats.
    assign count_now = v1 && c1 && (e1 == epoch) && (state == ST_MEASURE);

    pn_round_sat #(
        .IN_W  (IN_WDTH),
        .OUT_W (OUT_WDTH)
    ) u_round_sat (
        .din  (d1),
        .g    (g1),
        .dout (rs_dout),
        .sat  (rs_sat),
        .mag  (rs_mag)
    );

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            v1      <= 1'b0;
            d1      <= '0;
            g1      <= '0;
            c1      <= 1'b0;
            e1      <= 1'b0;
            DoutVld <= 1'b0;
            Dout    <= '0;
            SatFlag <= 1'b0;
            GainOut <= '0;
        end else begin
            v1 <= DinVld;
            if (DinVld) begin
                d1 <= Din;
                g1 <= g_use;
                c1 <= (state == ST_MEASURE);
                e1 <= epoch;
            end
            DoutVld <= v1;
            if (v1) begin
                Dout    <= rs_dout;
                SatFlag <= rs_sat;
                GainOut <= g1;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= ST_MANUAL;
            g_reg    <= '0;
            epoch    <= 1'b0;
            win_cnt  <= '0;
            peak     <= '0;
            sat_seen <= 1'b0;
        end else if (!AutoEn) begin
            state    <= ST_MANUAL;
            g_reg    <= g_man;
            win_cnt  <= '0;
            peak     <= '0;
            sat_seen <= 1'b0;
        end else begin
            case (state)
                ST_MANUAL: begin
                    state    <= ST_MEASURE;
                    g_reg    <= g_man;
                    epoch    <= ~epoch;
                    win_cnt  <= '0;
                    peak     <= '0;
                    sat_seen <= 1'b0;
                end
                ST_MEASURE: begin
                    if (count_now) begin
                        sat_seen <= sat_seen | rs_sat;
                        if (rs_mag > peak) begin
                            peak <= rs_mag;
                        end
                        if (win_cnt == LAST) begin
                            state   <= ST_ADJUST;
                            epoch   <= ~epoch;
                            win_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                end
                ST_ADJUST: begin
                    if (sat_seen && (g_reg != '0)) begin
                        g_reg <= g_reg - 1'b1;
                    end else if ((peak < LOW_PEAK) && (g_reg < GMAX_G)) begin
                        g_reg <= g_reg + 1'b1;
                    end
                    state    <= ST_MEASURE;
                    win_cnt  <= '0;
                    peak     <= '0;
                    sat_seen <= 1'b0;
                end
                default: begin
                    state <= ST_MANUAL;
                end
            endcase
        end
    end

endmodule
